iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
Multi-cycle radix-2 restoring divider. It is the sequential, parametrised successor to the combinational array divider. It trades latency for area by resolving BITS_PER_CYCLE quotient bits per clock, and supports runtime signed/unsigned mode. A start/ready/valid handshake lets a controller or datapath FSM issue back-to-back divisions.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
BITS_PER_CYCLE, 1, quotient bits resolved per clock; must divide WIDTH (1, 2, 4 legal)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous active-high reset
start_in  input  1  request; accepted only when ready_out=1
signed_in  input  1  1 = two's complement operands, 0 = unsigned; sampled with start
dividend_in  input  WIDTH  dividend, sampled on accepting edge
divisor_in  input  WIDTH  divisor, sampled on accepting edge
ready_out  output  1  block idle, can accept start
valid_out  output  1  one-cycle pulse: results valid
quotient_out  output  WIDTH  quotient, held until next valid_out
remainder_out  output  WIDTH  remainder, held until next valid_out
dbz_out  output  1  divisor was zero; held with results
ovf_out  output  1  signed most-negative / -1 overflow; held with results

Behaviour:
- Clock and reset: one clock (clk_in); reset rst_in is asynchronous, active-high.
- Reset values: ready_out=1, valid_out=0, quotient_out=0, remainder_out=0, dbz_out=0, ovf_out=0; FSM in IDLE.
- Reset mid-operation aborts immediately; no valid_out is produced for the aborted request.
- FSM states: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE: ready_out=1. When start_in=1, latch the operands and signed_in, then go to PREP.
- PREP (1 cycle):
  - Form operand magnitudes: negate when signed_in=1 and the MSB is set.
  - Record the quotient sign (dividend MSB xor divisor MSB) and the remainder sign (dividend MSB).
  - Clear the partial remainder.
  - Load the iteration counter with ITER = WIDTH/BITS_PER_CYCLE.
- RUN (ITER cycles), per sub-step:
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude using a WIDTH+1 bit subtract.
  - If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - Sub-steps are chained combinationally within one cycle.
- FIX (1 cycle):
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register outputs, assert valid_out for exactly this next cycle, go to IDLE.
- Latency: valid_out is high in cycle ITER+2 after the accepting edge. Example: WIDTH=16, BITS_PER_CYCLE=1 gives valid_out 18 cycles after acceptance.
- ready_out:
  - Deasserts on the accepting edge.
  - Reasserts in the same cycle valid_out is high, so back-to-back starts are allowed.
  - start_in while ready_out=0 is ignored, not queued.
- Signed semantics:
  - Truncation toward zero; the remainder takes the dividend's sign.
  - Invariant: dividend = quotient*divisor + remainder.
- Unsigned mode: no sign handling.
- Overflow: signed_in=1, dividend=100...0, divisor=all ones gives quotient_out=100...0, remainder_out=0, ovf_out=1. ovf_out is always 0 in unsigned mode.
- Divide by zero: dbz_out=1 whenever the latched divisor == 0.
  - Default (no macro): full latency; quotient magnitude = all ones, remainder magnitude = dividend magnitude, then the sign fix is applied.
- Outputs change only in the FIX cycle; between operations they hold the last result.

Optional Feature:
ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN
- Defined: a zero divisor is detected in PREP, and the FSM jumps straight to FIX. valid_out is asserted 2 cycles after acceptance with:
  - quotient_out = all ones
  - remainder_out = the original dividend_in
  - dbz_out = 1
  - ovf_out = 0
- Not defined: a zero divisor runs the full ITER+2 latency with the default divide-by-zero results above.

Test Plan:
- Unsigned basic (WIDTH=16, BITS_PER_CYCLE=1): signed_in=0, 100/7 -> quotient 14, remainder 2, dbz=0, ovf=0; valid_out exactly 18 cycles after the accepting edge.
- Signed mixed (signed_in=1):
  - -100/7 -> quotient 0xFFF2, remainder 0xFFFE.
  - 100/-7 -> quotient 0xFFF2, remainder 0x0002.
  - 0xFF00/0x0010 unsigned -> quotient 0x0FF0, remainder 0.
- Overflow and corner: signed 0x8000/0xFFFF -> quotient 0x8000, remainder 0, ovf=1. The same operands unsigned -> quotient 0, remainder 0x8000, ovf=0.
- Divide by zero: 1234/0 unsigned -> dbz=1, quotient 0xFFFF, remainder 1234. Latency is 18 without the macro and 2 with ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN.
- Handshake:
  - A start pulse at cycle 5 of a busy division is ignored: one valid_out only.
  - start held high across valid_out launches the next division on that edge; its result arrives 18 cycles later.
  - BITS_PER_CYCLE=4 gives latency 6 with identical results.
- Reset mid-operation: assert rst_in 8 cycles into a division -> outputs immediately 0, ready_out=1, no valid_out. A fresh 50/5 gives quotient 10, remainder 0.

Source files
------------

// File: rtl/iterative_divider.sv
// ============================================================================
//  Module   : iterative_divider
//  Purpose  : Multi-cycle radix-2 restoring divider with runtime signed or
//             unsigned mode. Resolves BITS_PER_CYCLE quotient bits per clock
//             and uses a start/ready/valid handshake.
//  Params   : WIDTH          - operand/result width (>= 4)
//             BITS_PER_CYCLE - quotient bits per clock (must divide WIDTH)
//  Ports    : clk_in        in   clock, rising edge
//             rst_in        in   asynchronous active-high reset
//             start_in      in   request, accepted only while ready_out=1
//             signed_in     in   1 = two's complement operands
//             dividend_in   in   [WIDTH]  dividend, sampled on accept
//             divisor_in    in   [WIDTH]  divisor, sampled on accept
//             ready_out     out  idle, can accept a start
//             valid_out     out  one-cycle result strobe
//             quotient_out  out  [WIDTH] quotient (held until next valid)
//             remainder_out out  [WIDTH] remainder (held until next valid)
//             dbz_out       out  divisor was zero
//             ovf_out       out  signed most-negative / -1 overflow
//  Options  : ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN - when defined, a zero
//             divisor skips the iterations and returns after 2 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_divider #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             dbz_out,
  output logic             ovf_out
);

  localparam int               C_ITER     = WIDTH / BITS_PER_CYCLE;
  localparam int               C_CW       = $clog2(C_ITER + 1);
  localparam logic [C_CW-1:0]  C_ITER_LD  = C_CW'(C_ITER);
  localparam logic [C_CW-1:0]  C_ONE      = C_CW'(1);
  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dividend;   // operands as accepted
  logic [WIDTH-1:0] r_divisor;
  logic             r_signed;
  logic [WIDTH-1:0] r_dvs_mag;    // divisor magnitude
  logic [WIDTH-1:0] r_rem;        // partial remainder
  logic [WIDTH-1:0] r_quo;        // dividend bits out at MSB, quotient bits in at LSB
  logic [C_CW-1:0]  r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_dvs_zero;

  assign w_dvd_neg  = r_signed & r_dividend[WIDTH-1];
  assign w_dvs_neg  = r_signed & r_divisor[WIDTH-1];
  assign w_dvs_zero = (r_divisor == '0);

  // --------------------------------------------------------------------------
  // Combinational chain of BITS_PER_CYCLE restoring sub-steps.
  // The partial remainder is always below the divisor magnitude, so the
  // shifted value is below twice the divisor and bit WIDTH of a WIDTH+1 bit
  // difference is exactly the borrow. With a zero divisor the remainder only
  // ever holds the dividend bits shifted in so far, so the shifted MSB stays 0,
  // no borrow occurs and the quotient fills with ones.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_rem_chain [0:BITS_PER_CYCLE];
  logic [WIDTH-1:0] w_quo_chain [0:BITS_PER_CYCLE];

  assign w_rem_chain[0] = r_rem;
  assign w_quo_chain[0] = r_quo;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [WIDTH:0] w_shift;
      logic [WIDTH:0] w_diff;
      logic           w_borrow;

      assign w_shift  = {w_rem_chain[gi], w_quo_chain[gi][WIDTH-1]};
      assign w_diff   = w_shift - {1'b0, r_dvs_mag};
      assign w_borrow = w_diff[WIDTH];

      assign w_rem_chain[gi+1] = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      assign w_quo_chain[gi+1] = {w_quo_chain[gi][WIDTH-2:0], ~w_borrow};
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_signed      <= 1'b0;
      r_dvs_mag     <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_cnt         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dbz         <= 1'b0;
      r_ovf         <= 1'b0;
      ready_out     <= 1'b1;
      valid_out     <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
      dbz_out       <= 1'b0;
      ovf_out       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_dividend <= dividend_in;
            r_divisor  <= divisor_in;
            r_signed   <= signed_in;
            ready_out  <= 1'b0;
            r_state    <= S_PREP;
          end
        end

        S_PREP: begin
          r_quo     <= w_dvd_neg ? -r_dividend : r_dividend;
          r_dvs_mag <= w_dvs_neg ? -r_divisor  : r_divisor;
          r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
          r_r_neg   <= w_dvd_neg;
          r_rem     <= '0;
          r_cnt     <= C_ITER_LD;
          r_dbz     <= w_dvs_zero;
          r_ovf     <= r_signed && (r_dividend == C_MOST_NEG) && (&r_divisor);
`ifdef ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN
          r_state   <= w_dvs_zero ? S_FIX : S_RUN;
`else
          r_state   <= S_RUN;
`endif
        end

        S_RUN: begin
          r_rem <= w_rem_chain[BITS_PER_CYCLE];
          r_quo <= w_quo_chain[BITS_PER_CYCLE];
          r_cnt <= r_cnt - C_ONE;
          if (r_cnt == C_ONE) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // Most-negative / -1 needs no special case: the magnitude quotient
          // is already the most-negative pattern and both signs cancel.
          quotient_out  <= r_q_neg ? -r_quo : r_quo;
          remainder_out <= r_r_neg ? -r_rem : r_rem;
          dbz_out       <= r_dbz;
          ovf_out       <= r_ovf;
`ifdef ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN
          if (r_dbz) begin
            quotient_out  <= '1;
            remainder_out <= r_dividend;
          end
`endif
          valid_out <= 1'b1;
          ready_out <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider.sv
// ============================================================================
//  Module   : tb_iterative_divider
//  Purpose  : Self-checking bench for iterative_divider. Drives two instances
//             (1 and 4 bits per cycle) with the same operands: table vectors,
//             handshake/reset sequences and random operands checked against
//             an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_divider;

  localparam int W = 16;

  typedef struct packed {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    logic [7:0]   lat;
    logic [7:0]   nvalid;
    logic [W-1:0] hq;
  } res_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sgn_in;
  logic [W-1:0] dvd;
  logic [W-1:0] dvs;

  logic         rdy1, v1, dbz1, ovf1;
  logic [W-1:0] q1, r1;
  logic         rdy4, v4, dbz4, ovf4;
  logic [W-1:0] q4, r4;

  int n_checks = 0;
  int n_err    = 0;

  iterative_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .signed_in(sgn_in),
    .dividend_in(dvd), .divisor_in(dvs),
    .ready_out(rdy1), .valid_out(v1), .quotient_out(q1), .remainder_out(r1),
    .dbz_out(dbz1), .ovf_out(ovf1)
  );

  iterative_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .signed_in(sgn_in),
    .dividend_in(dvd), .divisor_in(dvs),
    .ready_out(rdy4), .valid_out(v4), .quotient_out(q4), .remainder_out(r4),
    .dbz_out(dbz4), .ovf_out(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b, input int full);
`ifdef ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN
    if (b == '0) return 2;
`endif
    return full;
  endfunction

  // Reference model: plain integer division rules.
  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output logic ovf);
    int ia, ib;
    dbz = (b == '0);
    ovf = 1'b0;
    ia  = sgn ? int'($signed(a)) : int'({16'd0, a});
    ib  = sgn ? int'($signed(b)) : int'({16'd0, b});
    if (b == '0) begin
`ifdef ITERATIVE_DIVIDER_DBZ_SHORTCUT_EN
      q = 16'hFFFF;
      r = a;
`else
      // magnitude all ones, negated when the dividend is negative (-65535 = 1)
      q = (sgn && ia < 0) ? 16'h0001 : 16'hFFFF;
      // -|a| for negative a, |a| otherwise: both equal the original bits
      r = a;
`endif
    end else if (sgn && ia == -32768 && ib == -1) begin
      q   = 16'h8000;
      r   = 16'h0000;
      ovf = 1'b1;
    end else begin
      q = 16'(ia / ib);
      r = 16'(ia % ib);
    end
  endtask

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_at, output res_t g1, output res_t g4);
    int w;
    g1 = '0;
    g4 = '0;
    w  = 0;
    while (!(rdy1 && rdy4) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk("idle_wait_timeout", 32'(w), 32'(0));
    sgn_in = sgn; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_drop", {30'd0, rdy1, rdy4}, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      if (k == poke_at) begin
        start = 1'b1; dvd = 16'h1111; dvs = 16'h0001;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (v1) begin
        if (g1.nvalid == 0) begin
          g1.q = q1; g1.r = r1; g1.dbz = dbz1; g1.ovf = ovf1; g1.lat = 8'(k);
          chk("ready_at_valid1", 32'(rdy1), 32'd1);
        end
        g1.nvalid++;
      end
      if (v4) begin
        if (g4.nvalid == 0) begin
          g4.q = q4; g4.r = r4; g4.dbz = dbz4; g4.ovf = ovf4; g4.lat = 8'(k);
          chk("ready_at_valid4", 32'(rdy4), 32'd1);
        end
        g4.nvalid++;
      end
    end
    g1.hq = q1;
    g4.hq = q4;
  endtask

  task automatic check_res(input string tag, input res_t g, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic dbz, input logic ovf,
                           input int lat);
    chk({tag, "_quotient"},  32'(g.q),      32'(q));
    chk({tag, "_remainder"}, 32'(g.r),      32'(r));
    chk({tag, "_dbz"},       32'(g.dbz),    32'(dbz));
    chk({tag, "_ovf"},       32'(g.ovf),    32'(ovf));
    chk({tag, "_latency"},   32'(g.lat),    32'(lat));
    chk({tag, "_nvalid"},    32'(g.nvalid), 32'd1);
    chk({tag, "_hold_q"},    32'(g.hq),     32'(q));
  endtask

  vec_t         vecs [0:8];
  res_t         g1, g4;
  logic [W-1:0] eq, er, ra, rb;
  logic         edbz, eovf, rs;
  int           sel, lat, nv;
  logic         seen;

  initial begin
    vecs[0] = '{1'b0, 16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'hFF9C,  16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'd100,   16'hFFF9,   16'hFFF2,   16'h0002,   1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'hFF00,  16'h0010,   16'h0FF0,   16'h0000,   1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000,  16'hFFFF,   16'h8000,   16'h0000,   1'b0, 1'b1};
    vecs[5] = '{1'b0, 16'h8000,  16'hFFFF,   16'h0000,   16'h8000,   1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'd1234,  16'd0,      16'hFFFF,   16'd1234,   1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'd50,    16'd5,      16'd10,     16'd0,      1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sgn_in = 1'b0; dvd = '0; dvs = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready",     32'({rdy1, rdy4}), 32'd3);
    chk("reset_valid",     32'({v1, v4}),     32'd0);
    chk("reset_quotient",  32'(q1 | q4),      32'd0);
    chk("reset_remainder", 32'(r1 | r4),      32'd0);
    chk("reset_flags",     32'({dbz1, ovf1, dbz4, ovf4}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, -1, g1, g4);
      check_res($sformatf("vec%0d_b1", i), g1, vecs[i].q, vecs[i].r, vecs[i].dbz,
                vecs[i].ovf, exp_lat(vecs[i].b, 18));
      check_res($sformatf("vec%0d_b4", i), g4, vecs[i].q, vecs[i].r, vecs[i].dbz,
                vecs[i].ovf, exp_lat(vecs[i].b, 6));
    end

    // Start pulse while busy is ignored
    run_op(1'b0, 16'd100, 16'd7, 5, g1, g4);
    check_res("busy_b1", g1, 16'd14, 16'd2, 1'b0, 1'b0, 18);
    check_res("busy_b4", g4, 16'd14, 16'd2, 1'b0, 1'b0, 6);

    // Start held across valid_out launches the next division (1-bit instance)
    while (!(rdy1 && rdy4)) begin @(posedge clk); #1; end
    sgn_in = 1'b0; dvd = 16'd100; dvs = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    dvd = 16'd50; dvs = 16'd5;
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (v1) begin seen = 1'b1; lat = k; ra = q1; rb = r1; end
    end
    chk("b2b_first_latency", 32'(lat), 32'd18);
    chk("b2b_first_quotient", 32'(ra), 32'd14);
    chk("b2b_first_remainder", 32'(rb), 32'd2);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", 32'(rdy1), 32'd0);
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (v1) begin seen = 1'b1; lat = k; ra = q1; rb = r1; end
    end
    chk("b2b_second_latency", 32'(lat), 32'd18);
    chk("b2b_second_quotient", 32'(ra), 32'd10);
    chk("b2b_second_remainder", 32'(rb), 32'd0);
    repeat (30) @(posedge clk);
    #1;

    // Reset eight cycles into a division
    sgn_in = 1'b0; dvd = 16'd1000; dvs = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_quotient1",  32'(q1), 32'd0);
    chk("midrst_remainder1", 32'(r1), 32'd0);
    chk("midrst_ready1",     32'(rdy1), 32'd1);
    chk("midrst_valid1",     32'(v1), 32'd0);
    chk("midrst_quotient4",  32'(q4), 32'd0);
    chk("midrst_ready4",     32'(rdy4), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (v1) nv++;
    end
    chk("midrst_no_valid", 32'(nv), 32'd0);
    run_op(1'b0, 16'd50, 16'd5, -1, g1, g4);
    check_res("postrst_b1", g1, 16'd10, 16'd0, 1'b0, 1'b0, 18);
    check_res("postrst_b4", g4, 16'd10, 16'd0, 1'b0, 1'b0, 6);

    // Random operands against the reference model
    for (int i = 0; i < 150; i++) begin
      rs  = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2:       begin ra = 16'h8000; rb = 16'($urandom); end
        3, 4, 5: rb = 16'($urandom_range(1, 31));
        default: rb = 16'($urandom);
      endcase
      model(rs, ra, rb, eq, er, edbz, eovf);
      run_op(rs, ra, rb, -1, g1, g4);
      check_res($sformatf("rnd%0d_b1", i), g1, eq, er, edbz, eovf, exp_lat(rb, 18));
      check_res($sformatf("rnd%0d_b4", i), g4, eq, er, edbz, eovf, exp_lat(rb, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
